entrada_calculadora_n: RTL



---
 rtl/calc_pkg.sv | 30 +++
 rtl/entrada_calculadora_n_if.sv | 35 +++
 rtl/bcd_operando.sv | 68 ++++++
 rtl/entrada_calculadora_n.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// =============================================================================
// Module  : calc_pkg
// Brief   : Shared types, default key codes and helpers for the calculator entry
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package calc_pkg;

   typedef enum logic [2:0] {
      A_VAZIO   = 3'd0,
      A_ENTRADA = 3'd1,
      B_VAZIO   = 3'd2,
      B_ENTRADA = 3'd3,
      RESULTADO = 3'd4
   } estado_t;

   localparam logic [3:0] c_key_add  = 4'd10;
   localparam logic [3:0] c_key_sub  = 4'd11;
   localparam logic [3:0] c_key_clr  = 4'd12;
   localparam logic [3:0] c_key_bksp = 4'd13;
   localparam logic [3:0] c_key_eq   = 4'd15;

   function automatic logic eh_digito(input logic [3:0] teclas);
      return (teclas <= 4'd9);
   endfunction

endpackage

`default_nettype wire

// File: rtl/entrada_calculadora_n_if.sv
// =============================================================================
// Module  : entrada_calculadora_n_if
// Brief   : Keypad-side handshake and operand outputs of the entry controller
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

interface entrada_calculadora_n_if #(
   parameter int DIGITS = 7
);
   localparam int CW = $clog2(DIGITS + 1);

   logic                  ready;
   logic [3:0]            teclas;
   logic [4*DIGITS-1:0]   saida_a;
   logic [4*DIGITS-1:0]   saida_b;
   logic [CW-1:0]         cnt_a;
   logic [CW-1:0]         cnt_b;
   logic                  sinal;
   logic                  igual;
   logic                  erro;

   modport master (
      output ready, teclas,
      input  saida_a, saida_b, cnt_a, cnt_b, sinal, igual, erro
   );

   modport slave (
      input  ready, teclas,
      output saida_a, saida_b, cnt_a, cnt_b, sinal, igual, erro
   );

endinterface

`default_nettype wire

// File: rtl/bcd_operando.sv
// =============================================================================
// Module  : bcd_operando
// Brief   : Packed BCD operand register with digit counter (shift/load/delete)
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module bcd_operando #(
   parameter int DIGITS = 7
) (
   input  wire logic                          clk,
   input  wire logic                          reset,
   input  wire logic                          load,
   input  wire logic                          shift_in,
   input  wire logic                          shift_out,
   input  wire logic                          clear,
   input  wire logic [3:0]                    digit,
   output logic      [4*DIGITS-1:0]           value,
   output logic      [$clog2(DIGITS+1)-1:0]   cnt,
   output logic                               full,
   output logic                               empty
);
   localparam int CW = $clog2(DIGITS + 1);

   logic [4*DIGITS-1:0] r_value;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] w_shl;
   logic [4*DIGITS-1:0] w_shr;

   // A single-digit operand has no upper digits to carry along the shift
   generate
      if (DIGITS == 1) begin : g_one
         assign w_shl = digit;
         assign w_shr = '0;
      end else begin : g_multi
         assign w_shl = {r_value[4*DIGITS-5:0], digit};
         assign w_shr = {4'h0, r_value[4*DIGITS-1:4]};
      end
   endgenerate

   assign full  = (r_cnt == CW'(DIGITS));
   assign empty = (r_cnt == '0);
   assign value = r_value;
   assign cnt   = r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_value <= '0;
         r_cnt   <= '0;
      end else if (clear) begin
         r_value <= '0;
         r_cnt   <= '0;
      end else if (load) begin
         r_value      <= '0;
         r_value[3:0] <= digit;
         r_cnt        <= CW'(1);
      end else if (shift_in && !full) begin
         r_value <= w_shl;
         r_cnt   <= r_cnt + CW'(1);
      end else if (shift_out && !empty) begin
         r_value <= w_shr;
         r_cnt   <= r_cnt - CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/entrada_calculadora_n.sv
// =============================================================================
// Module  : entrada_calculadora_n
// Brief   : Keypad entry FSM building BCD operands A/B, operator and equals flag
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module entrada_calculadora_n
   import calc_pkg::*;
#(
   parameter int         DIGITS   = 7,
   parameter logic [3:0] KEY_ADD  = c_key_add,
   parameter logic [3:0] KEY_SUB  = c_key_sub,
   parameter logic [3:0] KEY_CLR  = c_key_clr,
   parameter logic [3:0] KEY_BKSP = c_key_bksp,
   parameter logic [3:0] KEY_EQ   = c_key_eq
) (
   input  wire logic                clk,
   input  wire logic                reset,
   entrada_calculadora_n_if.slave   bus
);
   localparam int CW = $clog2(DIGITS + 1);

   localparam logic [2:0] c_st_a_vazio   = A_VAZIO;
   localparam logic [2:0] c_st_a_entrada = A_ENTRADA;
   localparam logic [2:0] c_st_b_vazio   = B_VAZIO;
   localparam logic [2:0] c_st_b_entrada = B_ENTRADA;
   localparam logic [2:0] c_st_resultado = RESULTADO;

   logic [2:0]    r_estado;
   logic          r_ready_q;
   logic          r_sinal;
   logic          r_igual;
   logic          r_erro;

   logic          w_strobe;
   logic          w_dig;
   logic          w_a_load, w_a_shift_in, w_a_shift_out, w_a_clear;
   logic          w_b_load, w_b_shift_in, w_b_shift_out, w_b_clear;
   logic          w_a_full, w_a_empty, w_b_full, w_b_empty;
   logic [CW-1:0] w_a_cnt, w_b_cnt;

   assign w_strobe  = bus.ready && !r_ready_q;
   assign w_dig     = eh_digito(bus.teclas);
   assign bus.cnt_a = w_a_cnt;
   assign bus.cnt_b = w_b_cnt;
   assign bus.sinal = r_sinal;
   assign bus.igual = r_igual;
   assign bus.erro  = r_erro;

   // Operand datapath controls, decoded from the key accepted this cycle
   always_comb begin
      w_a_load      = 1'b0;
      w_a_shift_in  = 1'b0;
      w_a_shift_out = 1'b0;
      w_a_clear     = 1'b0;
      w_b_load      = 1'b0;
      w_b_shift_in  = 1'b0;
      w_b_shift_out = 1'b0;
      w_b_clear     = 1'b0;
      if (w_strobe) begin
         if (bus.teclas == KEY_CLR) begin
            w_a_clear = 1'b1;
            w_b_clear = 1'b1;
         end else begin
            case (r_estado)
               c_st_a_vazio:   w_a_load = w_dig;
               c_st_a_entrada: begin
                  w_a_shift_in  = w_dig && !w_a_full;
                  w_a_shift_out = (bus.teclas == KEY_BKSP) && !w_a_empty;
               end
               c_st_b_vazio:   w_b_load = w_dig;
               c_st_b_entrada: begin
                  w_b_shift_in  = w_dig && !w_b_full;
                  w_b_shift_out = (bus.teclas == KEY_BKSP) && !w_b_empty;
               end
               c_st_resultado: begin
                  w_a_load  = w_dig;
                  w_b_clear = w_dig;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado  <= c_st_a_vazio;
         r_ready_q <= 1'b0;
         r_sinal   <= 1'b0;
         r_igual   <= 1'b0;
         r_erro    <= 1'b0;
      end else begin
         r_ready_q <= bus.ready;
         r_erro    <= 1'b0;
         if (w_strobe) begin
            if (bus.teclas == KEY_CLR) begin
               r_estado <= c_st_a_vazio;
               r_sinal  <= 1'b0;
               r_igual  <= 1'b0;
            end else begin
               case (r_estado)
                  c_st_a_vazio: begin
                     if (w_dig) r_estado <= c_st_a_entrada;
                  end
                  c_st_a_entrada: begin
                     if (w_dig) begin
                        r_erro <= w_a_full;
                     end else if (bus.teclas == KEY_ADD || bus.teclas == KEY_SUB) begin
                        r_sinal  <= (bus.teclas == KEY_SUB);
                        r_estado <= c_st_b_vazio;
                     end else if (bus.teclas == KEY_BKSP && w_a_cnt == CW'(1)) begin
                        r_estado <= c_st_a_vazio;
                     end
                  end
                  c_st_b_vazio: begin
                     if (w_dig) begin
                        r_estado <= c_st_b_entrada;
                     end else if (bus.teclas == KEY_ADD || bus.teclas == KEY_SUB) begin
                        r_sinal <= (bus.teclas == KEY_SUB);
                     end else if (bus.teclas == KEY_BKSP) begin
                        r_estado <= c_st_a_entrada;
                     end
                  end
                  c_st_b_entrada: begin
                     if (w_dig) begin
                        r_erro <= w_b_full;
                     end else if (bus.teclas == KEY_BKSP && w_b_cnt == CW'(1)) begin
                        r_estado <= c_st_b_vazio;
                     end else if (bus.teclas == KEY_EQ) begin
                        r_igual  <= 1'b1;
                        r_estado <= c_st_resultado;
                     end
                  end
                  c_st_resultado: begin
                     if (w_dig) begin
                        r_igual  <= 1'b0;
                        r_estado <= c_st_a_entrada;
                     end
                  end
                  default: r_estado <= c_st_a_vazio;
               endcase
            end
         end
      end
   end

   bcd_operando #(.DIGITS(DIGITS)) u_op_a (
      .clk       (clk),
      .reset     (reset),
      .load      (w_a_load),
      .shift_in  (w_a_shift_in),
      .shift_out (w_a_shift_out),
      .clear     (w_a_clear),
      .digit     (bus.teclas),
      .value     (bus.saida_a),
      .cnt       (w_a_cnt),
      .full      (w_a_full),
      .empty     (w_a_empty)
   );

   bcd_operando #(.DIGITS(DIGITS)) u_op_b (
      .clk       (clk),
      .reset     (reset),
      .load      (w_b_load),
      .shift_in  (w_b_shift_in),
      .shift_out (w_b_shift_out),
      .clear     (w_b_clear),
      .digit     (bus.teclas),
      .value     (bus.saida_b),
      .cnt       (w_b_cnt),
      .full      (w_b_full),
      .empty     (w_b_empty)
   );

endmodule

`default_nettype wire
